// File: rtl/ipl_irq_tracker_if.sv
// -----------------------------------------------------------------------------
// ipl_irq_tracker_if
//
// Purpose : groups the IPL inputs, the host mask/acknowledge handshake and the
//           interrupt request outputs of ipl_irq_tracker into one bundle.
//
// Signals :
//   IPL_N     [2:0]  synchronized IPL pins, active-low (level = ~IPL_N)
//   IPL_MASK  [2:0]  current CPU SR interrupt mask from the host
//   ACK              single-cycle pulse: host has taken the interrupt
//   ACK_LEVEL [2:0]  level the host claims to acknowledge (valid with ACK)
//   IRQ              registered interrupt request to the host
//   IRQ_LEVEL [2:0]  level being requested, 0 when IRQ = 0
//   ACK_OK           pulse: acknowledge accepted
//   SPURIOUS         pulse: acknowledge rejected
//   IRQ_COUNT [15:0] accepted-ack counter (only with IPL_IRQ_COUNT_EN defined)
//
// Modports:
//   master : the tracker (consumes IPL/handshake inputs, drives the request)
//   slave  : the host side (drives IPL/handshake inputs, observes the request)
//
// Build option: IPL_IRQ_COUNT_EN adds the IRQ_COUNT signal.
// -----------------------------------------------------------------------------
interface ipl_irq_tracker_if;
  logic [2:0]  IPL_N;
  logic [2:0]  IPL_MASK;
  logic        ACK;
  logic [2:0]  ACK_LEVEL;
  logic        IRQ;
  logic [2:0]  IRQ_LEVEL;
  logic        ACK_OK;
  logic        SPURIOUS;

`ifdef IPL_IRQ_COUNT_EN
  logic [15:0] IRQ_COUNT;

  modport master (
    input  IPL_N, IPL_MASK, ACK, ACK_LEVEL,
    output IRQ, IRQ_LEVEL, ACK_OK, SPURIOUS, IRQ_COUNT
  );

  modport slave (
    output IPL_N, IPL_MASK, ACK, ACK_LEVEL,
    input  IRQ, IRQ_LEVEL, ACK_OK, SPURIOUS, IRQ_COUNT
  );
`else
  modport master (
    input  IPL_N, IPL_MASK, ACK, ACK_LEVEL,
    output IRQ, IRQ_LEVEL, ACK_OK, SPURIOUS
  );

  modport slave (
    output IPL_N, IPL_MASK, ACK, ACK_LEVEL,
    input  IRQ, IRQ_LEVEL, ACK_OK, SPURIOUS
  );
`endif
endinterface : ipl_irq_tracker_if

// File: rtl/ipl_irq_tracker.sv
// -----------------------------------------------------------------------------
// ipl_irq_tracker
//
// Purpose : turns the synchronized, active-low 68000 IPL pins into a registered
//           interrupt request for the host. Levels 1..6 are compared against
//           the host-supplied SR mask; level 7 (NMI) is edge-triggered and
//           unmaskable. A request/acknowledge handshake with hold-off and
//           spurious-ack detection sits on top.
//
// Ports   :
//   CLK    in   system clock (same domain as the IPL synchronizer output)
//   RESET  in   synchronous, active-high reset
//   bus    ipl_irq_tracker_if.master
//            IPL_N, IPL_MASK, ACK, ACK_LEVEL in;
//            IRQ, IRQ_LEVEL, ACK_OK, SPURIOUS (and IRQ_COUNT) out.
//            All outputs are registered.
//
// Parameters:
//   HOLDOFF_CYCLES  cycles IRQ is held low after an ack (1..255, 8-bit counter)
//   NMI_LEVEL       edge-triggered, unmaskable level (fixed at 7)
//
// Build option: define IPL_IRQ_COUNT_EN to add IRQ_COUNT, a 16-bit saturating
//               count of accepted acks, cleared by RESET.
// -----------------------------------------------------------------------------
module ipl_irq_tracker #(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int NMI_LEVEL      = 7
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ipl_irq_tracker_if.master    bus
);

  localparam logic [2:0] NMI_LVL      = 3'(NMI_LEVEL);
  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] prev_lvl_q;
  logic       nmi_pend_q, nmi_pend_d;
  logic       irq_q, irq_d;
  logic [2:0] irq_level_q, irq_level_d;
  logic       ack_ok_q, ack_ok_d;
  logic       spurious_q, spurious_d;

  logic [2:0] lvl;
  logic       nmi_edge;
  logic       nmi_active;
  logic       nmi_clr;
  logic       eligible;
  logic [2:0] req_lvl;

  // Level decode and eligibility. The NMI edge is folded in combinationally so
  // a fresh level-7 edge requests with the same 1-clock latency as any other
  // level change, rather than waiting for nmi_pend to register first.
  always_comb begin
    lvl        = ~bus.IPL_N;
    nmi_edge   = (prev_lvl_q != NMI_LVL) && (lvl == NMI_LVL);
    nmi_active = nmi_pend_q || nmi_edge;
    // A level held at 7 without a pending edge is never eligible.
    eligible   = nmi_active || ((lvl != NMI_LVL) && (lvl > bus.IPL_MASK));
    req_lvl    = nmi_active ? NMI_LVL : lvl;
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_ok_d   = 1'b0;
    spurious_d = 1'b0;
    nmi_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // An ack with nothing outstanding is only flagged; it does not
        // disturb the normal eligibility evaluation.
        if (bus.ACK) spurious_d = 1'b1;
        if (eligible) state_d = REQ;
      end

      REQ: begin
        if (bus.ACK) begin
          // Any ack, good or bad, starts the hold-off window.
          state_d = SERVICE;
          cnt_d   = HOLDOFF_LOAD;
          if ((bus.ACK_LEVEL == irq_level_q) && eligible) begin
            ack_ok_d = 1'b1;
            nmi_clr  = (bus.ACK_LEVEL == NMI_LVL);
          end else begin
            spurious_d = 1'b1;
          end
        end else if (!eligible) begin
          state_d = IDLE;
        end
      end

      SERVICE: begin
        if (bus.ACK) spurious_d = 1'b1;
        // The window covers exactly HOLDOFF_CYCLES low cycles of IRQ: on the
        // last one the counter reaches 0 and the idle-state evaluation is made
        // directly, so a still-eligible level re-requests without an extra
        // idle cycle.
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d   = 8'd0;
          state_d = eligible ? REQ : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // A new edge in the same cycle as the clear wins, keeping the NMI pending.
    nmi_pend_d  = nmi_edge || (nmi_pend_q && !nmi_clr);

    // Request outputs follow the next state so they change one clock after
    // the IPL change that caused them.
    irq_d       = (state_d == REQ);
    irq_level_d = irq_d ? req_lvl : 3'd0;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      // Level 7 already present at reset release must not look like an edge.
      prev_lvl_q  <= NMI_LVL;
      nmi_pend_q  <= 1'b0;
      irq_q       <= 1'b0;
      irq_level_q <= 3'd0;
      ack_ok_q    <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_lvl_q  <= lvl;
      nmi_pend_q  <= nmi_pend_d;
      irq_q       <= irq_d;
      irq_level_q <= irq_level_d;
      ack_ok_q    <= ack_ok_d;
      spurious_q  <= spurious_d;
    end
  end

  assign bus.IRQ       = irq_q;
  assign bus.IRQ_LEVEL = irq_level_q;
  assign bus.ACK_OK    = ack_ok_q;
  assign bus.SPURIOUS  = spurious_q;

`ifdef IPL_IRQ_COUNT_EN
  logic [15:0] irq_count_q;

  // Counts alongside the ACK_OK pulse; sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_count_q <= 16'd0;
    end else if (ack_ok_d && (irq_count_q != 16'hFFFF)) begin
      irq_count_q <= irq_count_q + 16'd1;
    end
  end

  assign bus.IRQ_COUNT = irq_count_q;
`else
  // No accepted-ack counter in this build.
`endif

endmodule : ipl_irq_tracker

// File: doc/ipl_irq_tracker.md
Name: ipl_irq_tracker

Overview:
- Sits directly downstream of the IPL synchronizer.
- Consumes the stable, synchronized active-low IPL pins and turns them into a registered interrupt request for the host (Pi) side.
- Enforces 68000 semantics:
  - Levels 1–6 are compared against the host-supplied SR mask.
  - Level 7 (NMI) is edge-triggered.
- Runs a request/acknowledge handshake with hold-off and spurious-ack detection.

Parameters:
- HOLDOFF_CYCLES, 4: number of cycles IRQ is forced low after an ack; legal range 1..255; 8-bit counter.
- NMI_LEVEL, 7: level treated as edge-triggered and unmaskable; fixed at 7 in this design, exposed only for the bench.

Ports:
- CLK  in  1  system clock, same domain as the IPL synchronizer output.
- RESET  in  1  synchronous, active-high reset.
- IPL_N  in  3  synchronized IPL from the synchronizer, active-low; level = ~IPL_N.
- IPL_MASK  in  3  current CPU SR interrupt mask, supplied by the host.
- ACK  in  1  single-cycle pulse: host has taken the interrupt.
- ACK_LEVEL  in  3  level the host claims to acknowledge; valid when ACK=1.
- IRQ  out  1  registered interrupt request to the host.
- IRQ_LEVEL  out  3  level being requested; 0 when IRQ=0.
- ACK_OK  out  1  pulse: valid ack accepted.
- SPURIOUS  out  1  pulse: ack rejected (wrong level, no request, or during hold-off).

Behaviour:
- Internal signals:
  - lvl = ~IPL_N.
  - prev_lvl: lvl registered every cycle.
  - nmi_pend: NMI pending flag.
  - eligible = nmi_pend OR (lvl != 7 AND lvl > IPL_MASK).
  - req_lvl = 7 if nmi_pend, else lvl.
- NMI edge: prev_lvl != 7 AND lvl == 7 sets nmi_pend.
  - Level held at 7 never re-triggers.
  - lvl must drop below 7 and return to 7 to produce a new edge.
- Reset values: IRQ=0, IRQ_LEVEL=0, ACK_OK=0, SPURIOUS=0, nmi_pend=0, state=IDLE, hold-off counter=0.
  - prev_lvl resets to 7, so IPL already at 7 when reset releases does NOT raise an NMI.
- All outputs are registered. Latency from an IPL_N change to IRQ/IRQ_LEVEL change is 1 clock.
- State IDLE:
  - IRQ=0, IRQ_LEVEL=0.
  - If eligible → REQ; next cycle IRQ=1, IRQ_LEVEL=req_lvl.
- State REQ:
  - IRQ=1; IRQ_LEVEL re-evaluated every cycle to the current req_lvl, so a higher level preempts immediately.
  - If not eligible and no ACK → IDLE (request withdrawn; IRQ=0, IRQ_LEVEL=0 next cycle).
  - ACK with ACK_LEVEL == IRQ_LEVEL and eligible:
    - ACK_OK pulse.
    - If the acked level is 7, clear nmi_pend.
    - → SERVICE.
  - ACK with any other condition: SPURIOUS pulse, → SERVICE. Hold-off still applies.
- State SERVICE:
  - IRQ=0, IRQ_LEVEL=0.
  - Counter loads HOLDOFF_CYCLES on entry and decrements each cycle.
  - At 0 → IDLE, then normal re-evaluation; a still-eligible level re-requests.
- ACK while in IDLE or SERVICE: SPURIOUS pulse, no state or counter change.
- Simultaneous NMI edge and nmi_pend clear in the same cycle: the set wins, so the pending NMI is kept.
- IPL_MASK changes take effect in the next eligible evaluation, with no extra latency.
- RESET asserted in any state: all registers return to reset values on the next edge; an in-flight hold-off is abandoned.

Optional Feature:
- Macro: IPL_IRQ_COUNT_EN.
- Defined:
  - Adds output IRQ_COUNT (16 bits).
  - Increments on every ACK_OK and saturates at 16'hFFFF.
  - Cleared by RESET.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset release with IPL_N=3'b000 (level 7) held → IRQ stays 0 for 20 cycles and nmi_pend stays 0.
- IPL_MASK=2, IPL_N=3'b010 (level 5) → IRQ=1 and IRQ_LEVEL=5 one cycle later. Then ACK with ACK_LEVEL=5 → ACK_OK pulse, IRQ=0 for exactly HOLDOFF_CYCLES (4) cycles, then IRQ=1 and IRQ_LEVEL=5 again while level 5 persists.
- IPL_MASK=7, level goes 0→7 → IRQ=1, IRQ_LEVEL=7. ACK with level 7 → ACK_OK. Hold level 7 for 50 cycles → no new IRQ. Drop to 0 then back to 7 → IRQ re-asserts.
- In REQ at level 3, raise to level 6 (mask 0) → IRQ_LEVEL=6 next cycle. Then ACK with ACK_LEVEL=3 → SPURIOUS pulse, no ACK_OK, IRQ=0 for the hold-off.
- IDLE, no eligible level, ACK pulse → SPURIOUS=1 for one cycle, IRQ stays 0. Level 4 with mask 4 → no request.
- In SERVICE with counter at 2, assert RESET for 1 cycle → all outputs 0 next cycle, state IDLE. With IPL_IRQ_COUNT_EN, 3 accepted acks → IRQ_COUNT=3, and RESET returns it to 0.
